// File: rtl/j1_ram_loader_if.sv
// Bus bundle for j1_ram_loader: UART-style byte stream, J1 data-write bus and RAM write port.
// master = environment side (byte source, J1 core, RAM), slave = the loader.
interface j1_ram_loader_if #(
  parameter int ADDR_W = 13
);
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              cpu_mem_wr;
  logic [15:0]       cpu_mem_addr;
  logic [31:0]       cpu_dout;
  logic              ram_wr;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;

  modport master (
    output rx_valid, rx_data, cpu_mem_wr, cpu_mem_addr, cpu_dout,
    input  rx_ready, ram_wr, ram_addr, ram_wdata
  );

  modport slave (
    input  rx_valid, rx_data, cpu_mem_wr, cpu_mem_addr, cpu_dout,
    output rx_ready, ram_wr, ram_addr, ram_wdata
  );
endinterface

// File: rtl/j1_ram_loader.sv
// Boot loader/arbiter for the J1 code RAM: streams N words into RAM from address 0, then releases the CPU.
// Define J1_LOADER_CHECKSUM_EN to require a trailing XOR byte (CSUM state) after the payload.
module j1_ram_loader #(
  parameter int ADDR_W    = 13,
  parameter int MAX_WORDS = 8192
) (
  input  logic           clk_i,
  input  logic           reset_i,
  input  logic           load_req_i,
  j1_ram_loader_if.slave bus,
  output logic           cpu_reset_o,
  output logic           loading_o,
  output logic           err_o,
  output logic [13:0]    words_loaded_o
);

  typedef enum logic [2:0] {
    HDR_LO = 3'd0,
    HDR_HI = 3'd1,
    DATA   = 3'd2,
`ifdef J1_LOADER_CHECKSUM_EN
    CSUM   = 3'd3,
`endif
    RUN    = 3'd4,
    ERR    = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  byte_cnt_q;
  logic [23:0] shift_q;
  logic        wr_pend_q;
  logic [31:0] wr_data_q;
  logic [13:0] words_q;
  logic [7:0]  n_lo_q;
  logic [13:0] n_q;
  logic        cpu_reset_q;
`ifdef J1_LOADER_CHECKSUM_EN
  logic [7:0]  csum_q;
  logic        csum_ok_s;
`endif

  logic        run_s;
  logic        rx_ready_s;
  logic        acc_s;
  logic [15:0] n_hdr_s;
  logic        last_wr_s;
  logic        data_byte_s;
  logic        unused_s;

  assign run_s       = (state_q == RUN);
  assign rx_ready_s  = ~run_s;
  assign acc_s       = bus.rx_valid & rx_ready_s;
  assign n_hdr_s     = {bus.rx_data, n_lo_q};
  // The cycle issuing the final word's write ends DATA; a byte arriving in it is not payload.
  assign last_wr_s   = (state_q == DATA) & wr_pend_q & ((words_q + 14'd1) == n_q);
  assign data_byte_s = acc_s & (state_q == DATA) & ~last_wr_s & ~load_req_i;
`ifdef J1_LOADER_CHECKSUM_EN
  assign csum_ok_s   = (bus.rx_data == csum_q);
`endif
  assign unused_s    = ^{bus.cpu_mem_addr[15], bus.cpu_mem_addr[1:0]};

  // Next-state logic; load_req overrides any accepted byte
  always_comb begin
    state_d = state_q;
    if (load_req_i) begin
      state_d = HDR_LO;
    end else begin
      case (state_q)
        HDR_LO: begin
          if (acc_s) state_d = HDR_HI;
          else       state_d = state_q;
        end
        HDR_HI: begin
          if (!acc_s) begin
            state_d = state_q;
          end else if (n_hdr_s == 16'd0) begin
`ifdef J1_LOADER_CHECKSUM_EN
            state_d = CSUM;
`else
            state_d = RUN;
`endif
          end else if (32'(n_hdr_s) > MAX_WORDS) begin
            state_d = ERR;
          end else begin
            state_d = DATA;
          end
        end
        DATA: begin
          if (last_wr_s) begin
`ifdef J1_LOADER_CHECKSUM_EN
            if (acc_s) state_d = csum_ok_s ? RUN : ERR;
            else       state_d = CSUM;
`else
            state_d = RUN;
`endif
          end else begin
            state_d = state_q;
          end
        end
`ifdef J1_LOADER_CHECKSUM_EN
        CSUM: begin
          if (acc_s) state_d = csum_ok_s ? RUN : ERR;
          else       state_d = state_q;
        end
`endif
        RUN:     state_d = state_q;
        ERR:     state_d = state_q;
        default: state_d = HDR_LO;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= HDR_LO;
    else         state_q <= state_d;
  end

  // Header capture, word assembly, write pipeline and word counter
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      byte_cnt_q  <= 2'd0;
      shift_q     <= 24'd0;
      wr_pend_q   <= 1'b0;
      wr_data_q   <= 32'd0;
      words_q     <= 14'd0;
      n_lo_q      <= 8'd0;
      n_q         <= 14'd0;
      cpu_reset_q <= 1'b1;
    end else begin
      wr_pend_q   <= data_byte_s & (byte_cnt_q == 2'd3);
      cpu_reset_q <= ~(run_s & ~load_req_i);
      if (data_byte_s) begin
        shift_q <= {bus.rx_data, shift_q[23:8]};
        if (byte_cnt_q == 2'd3) wr_data_q <= {bus.rx_data, shift_q};
      end
      if (load_req_i)       byte_cnt_q <= 2'd0;
      else if (data_byte_s) byte_cnt_q <= byte_cnt_q + 2'd1;
      if (load_req_i)     words_q <= 14'd0;
      else if (wr_pend_q) words_q <= words_q + 14'd1;
      if (acc_s && !load_req_i && state_q == HDR_LO) n_lo_q <= bus.rx_data;
      if (acc_s && !load_req_i && state_q == HDR_HI) n_q <= n_hdr_s[13:0];
    end
  end

`ifdef J1_LOADER_CHECKSUM_EN
  // Running XOR of payload bytes
  always_ff @(posedge clk_i) begin
    if (reset_i || load_req_i) csum_q <= 8'd0;
    else if (data_byte_s)      csum_q <= csum_q ^ bus.rx_data;
  end
`endif

  assign bus.rx_ready   = rx_ready_s;
  assign bus.ram_wr     = run_s ? bus.cpu_mem_wr : wr_pend_q;
  assign bus.ram_addr   = run_s ? bus.cpu_mem_addr[ADDR_W+1:2] : words_q[ADDR_W-1:0];
  assign bus.ram_wdata  = run_s ? bus.cpu_dout : wr_data_q;
  assign cpu_reset_o    = cpu_reset_q;
  assign loading_o      = (state_q == HDR_LO) | (state_q == HDR_HI) | (state_q == DATA)
`ifdef J1_LOADER_CHECKSUM_EN
                        | (state_q == CSUM)
`endif
                        ;
  assign err_o          = (state_q == ERR);
  assign words_loaded_o = words_q;

endmodule

// File: tb/tb_j1_ram_loader.sv
// Directed self-checking bench for j1_ram_loader; follows J1_LOADER_CHECKSUM_EN like the RTL.
module tb_j1_ram_loader;
  localparam int ADDR_W = 13;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_req;
  logic        cpu_reset;
  logic        loading;
  logic        err;
  logic [13:0] words_loaded;
  int          total = 0;
  int          bad = 0;

  logic [ADDR_W-1:0] wq_a[$];
  logic [31:0]       wq_d[$];

  j1_ram_loader_if #(.ADDR_W(ADDR_W)) bus ();

  j1_ram_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(8192)) dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .load_req_i    (load_req),
    .bus           (bus),
    .cpu_reset_o   (cpu_reset),
    .loading_o     (loading),
    .err_o         (err),
    .words_loaded_o(words_loaded)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.ram_wr === 1'b1) begin
      wq_a.push_back(bus.ram_addr);
      wq_d.push_back(bus.ram_wdata);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    tick();
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic restart();
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    wq_a.delete();
    wq_d.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    total++; if (loading !== 1'b1)   begin bad++; $display("FAIL reset_loading got=%b want=1", loading); end
    total++; if (cpu_reset !== 1'b1) begin bad++; $display("FAIL reset_cpu_reset got=%b want=1", cpu_reset); end
    total++; if (err !== 1'b0)       begin bad++; $display("FAIL reset_err got=%b want=0", err); end
    total++; if (words_loaded !== 14'd0) begin bad++; $display("FAIL reset_words got=%0d want=0", words_loaded); end
    total++; if (bus.ram_wr !== 1'b0 || bus.rx_ready !== 1'b1) begin bad++; $display("FAIL reset_ports got wr=%b rdy=%b want wr=0 rdy=1", bus.ram_wr, bus.rx_ready); end
  endtask

  task automatic test_load();
    wq_a.delete(); wq_d.delete();
    send_byte(8'h02); send_byte(8'h00);
    send_word(32'h11223344);
    send_word(32'hDEADBEEF);
    // one cycle after the 4th byte: the loader write is on the port
    total++; if (bus.ram_wr !== 1'b1 || bus.ram_addr !== 13'd1 || bus.ram_wdata !== 32'hDEADBEEF)
      begin bad++; $display("FAIL load_write_latency got wr=%b a=%0d d=%h want 1/1/deadbeef", bus.ram_wr, bus.ram_addr, bus.ram_wdata); end
`ifdef J1_LOADER_CHECKSUM_EN
    send_byte(8'h66);
`else
    tick();
`endif
    total++; if (loading !== 1'b0 || cpu_reset !== 1'b1) begin bad++; $display("FAIL load_enter_run got loading=%b cpu_reset=%b want 0/1", loading, cpu_reset); end
    total++; if (words_loaded !== 14'd2) begin bad++; $display("FAIL load_words got=%0d want=2", words_loaded); end
    tick();
    total++; if (cpu_reset !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL load_release got cpu_reset=%b err=%b want 0/0", cpu_reset, err); end
    total++; if (bus.rx_ready !== 1'b0) begin bad++; $display("FAIL load_run_ready got=%b want=0", bus.rx_ready); end
    total++; if (wq_a.size() != 2 || wq_a[0] !== 13'd0 || wq_d[0] !== 32'h11223344 || wq_a[1] !== 13'd1 || wq_d[1] !== 32'hDEADBEEF)
      begin bad++; $display("FAIL load_ram_writes got n=%0d a0=%0d d0=%h a1=%0d d1=%h want 2 0 11223344 1 deadbeef", wq_a.size(), wq_a[0], wq_d[0], wq_a[1], wq_d[1]); end
  endtask

`ifdef J1_LOADER_CHECKSUM_EN
  task automatic test_bad_csum();
    restart();
    send_byte(8'h02); send_byte(8'h00);
    send_word(32'h11223344);
    send_word(32'hDEADBEEF);
    send_byte(8'h01);
    total++; if (err !== 1'b1 || loading !== 1'b0) begin bad++; $display("FAIL csum_err got err=%b loading=%b want 1/0", err, loading); end
    repeat (3) tick();
    total++; if (cpu_reset !== 1'b1 || err !== 1'b1) begin bad++; $display("FAIL csum_hold got cpu_reset=%b err=%b want 1/1", cpu_reset, err); end
    total++; if (wq_a.size() != 2 || words_loaded !== 14'd2) begin bad++; $display("FAIL csum_writes got n=%0d words=%0d want 2/2", wq_a.size(), words_loaded); end
  endtask
`endif

  task automatic test_hdr_limits();
    restart();
    send_byte(8'h01); send_byte(8'h20);
    total++; if (err !== 1'b1 || loading !== 1'b0 || cpu_reset !== 1'b1) begin bad++; $display("FAIL hdr_over got err=%b loading=%b cpu_reset=%b want 1/0/1", err, loading, cpu_reset); end
    send_byte(8'h55);
    total++; if (err !== 1'b1 || wq_a.size() != 0 || words_loaded !== 14'd0) begin bad++; $display("FAIL hdr_over_discard got err=%b n=%0d words=%0d want 1/0/0", err, wq_a.size(), words_loaded); end
    restart();
    send_byte(8'h00); send_byte(8'h20);
    total++; if (err !== 1'b0 || loading !== 1'b1) begin bad++; $display("FAIL hdr_max got err=%b loading=%b want 0/1", err, loading); end
    restart();
    send_byte(8'h00); send_byte(8'h00);
`ifdef J1_LOADER_CHECKSUM_EN
    send_byte(8'h00);
`endif
    repeat (2) tick();
    total++; if (cpu_reset !== 1'b0 || err !== 1'b0 || loading !== 1'b0 || wq_a.size() != 0)
      begin bad++; $display("FAIL hdr_zero got cpu_reset=%b err=%b loading=%b n=%0d want 0/0/0/0", cpu_reset, err, loading, wq_a.size()); end
  endtask

  task automatic test_arbitration();
    restart();
    bus.cpu_mem_wr = 1'b1; bus.cpu_mem_addr = 16'h0010; bus.cpu_dout = 32'hCAFEF00D;
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h04);
    total++; if (bus.ram_wr !== 1'b0) begin bad++; $display("FAIL arb_cpu_ignored got=%b want=0", bus.ram_wr); end
    send_byte(8'h03); send_byte(8'h02); send_byte(8'h01);
    total++; if (bus.ram_wr !== 1'b1 || bus.ram_addr !== 13'd0 || bus.ram_wdata !== 32'h01020304)
      begin bad++; $display("FAIL arb_loader_owns got wr=%b a=%0d d=%h want 1/0/01020304", bus.ram_wr, bus.ram_addr, bus.ram_wdata); end
`ifdef J1_LOADER_CHECKSUM_EN
    send_byte(8'h04);
`else
    tick();
`endif
    #1;
    total++; if (bus.ram_wr !== 1'b1 || bus.ram_addr !== 13'd4 || bus.ram_wdata !== 32'hCAFEF00D)
      begin bad++; $display("FAIL arb_cpu_run got wr=%b a=%0d d=%h want 1/4/cafef00d", bus.ram_wr, bus.ram_addr, bus.ram_wdata); end
    bus.cpu_mem_wr = 1'b0;
    #1;
    total++; if (bus.ram_wr !== 1'b0) begin bad++; $display("FAIL arb_cpu_idle got=%b want=0", bus.ram_wr); end
    tick();
  endtask

  task automatic test_load_req_run();
    restart();
    total++; if (cpu_reset !== 1'b1 || bus.rx_ready !== 1'b1 || words_loaded !== 14'd0 || loading !== 1'b1)
      begin bad++; $display("FAIL lreq_run got cpu_reset=%b rdy=%b words=%0d loading=%b want 1/1/0/1", cpu_reset, bus.rx_ready, words_loaded, loading); end
    send_byte(8'h01); send_byte(8'h00);
    send_word(32'h12345678);
`ifdef J1_LOADER_CHECKSUM_EN
    send_byte(8'h08);
`else
    tick();
`endif
    tick();
    total++; if (cpu_reset !== 1'b0 || words_loaded !== 14'd1 || err !== 1'b0) begin bad++; $display("FAIL lreq_reload got cpu_reset=%b words=%0d err=%b want 0/1/0", cpu_reset, words_loaded, err); end
    total++; if (wq_a.size() != 1 || wq_a[0] !== 13'd0 || wq_d[0] !== 32'h12345678) begin bad++; $display("FAIL lreq_write got n=%0d a=%0d d=%h want 1/0/12345678", wq_a.size(), wq_a[0], wq_d[0]); end
  endtask

  task automatic test_restart_mid();
    restart();
    send_byte(8'h02); send_byte(8'h00);
    send_word(32'hA1B2C3D4);
    send_byte(8'hEE);
    total++; if (words_loaded !== 14'd1 || wq_a.size() != 1) begin bad++; $display("FAIL mid_first_word got words=%0d n=%0d want 1/1", words_loaded, wq_a.size()); end
    restart();
    total++; if (words_loaded !== 14'd0 || loading !== 1'b1) begin bad++; $display("FAIL mid_cleared got words=%0d loading=%b want 0/1", words_loaded, loading); end
    send_byte(8'h01); send_byte(8'h00);
    send_word(32'h0BADF00D);
`ifdef J1_LOADER_CHECKSUM_EN
    send_byte(8'h5B);
`else
    tick();
`endif
    tick();
    total++; if (wq_a.size() != 1 || wq_a[0] !== 13'd0 || wq_d[0] !== 32'h0BADF00D) begin bad++; $display("FAIL mid_fresh_write got n=%0d a=%0d d=%h want 1/0/0badf00d", wq_a.size(), wq_a[0], wq_d[0]); end
    total++; if (cpu_reset !== 1'b0 || err !== 1'b0 || words_loaded !== 14'd1) begin bad++; $display("FAIL mid_run got cpu_reset=%b err=%b words=%0d want 0/0/1", cpu_reset, err, words_loaded); end
  endtask

  initial begin
    reset = 1'b1; load_req = 1'b0;
    bus.rx_valid = 1'b0; bus.rx_data = 8'h00;
    bus.cpu_mem_wr = 1'b0; bus.cpu_mem_addr = 16'h0000; bus.cpu_dout = 32'h0;
    tick();
    test_reset();
    test_load();
`ifdef J1_LOADER_CHECKSUM_EN
    test_bad_csum();
`endif
    test_hdr_limits();
    test_arbitration();
    test_load_req_run();
    test_restart_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
